cond_logic: RTL
===============

Name: cond_logic

Overview:
- Conditional-execution stage of the single-cycle ARM core; sits between the decoder/ALU and the register file, memory and PC mux.
- Holds the architectural NZCV flag register, written per group (NZ, CV) under FlagW.
- Evaluates the instruction condition against the registered flags.
- Gates PC, register and memory writes, and keeps a saturating count of condition-failed instructions for performance monitoring.

Parameters:
- CNT_W, 16, width of the skipped-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- En  in  1  instruction-valid / not-stalled; commits only when 1.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  in  2  [1] = write NZ, [0] = write CV (from decoder).
- PCS  in  1  instruction writes PC.
- RegW  in  1  instruction writes register file.
- MemW  in  1  instruction writes memory.
- NoWrite  in  1  compare-type instruction; suppress register write.
- SkipClr  in  1  clear skipped-instruction counter.
- PCSrc  out  1  gated PC write.
- RegWrite  out  1  gated register write.
- MemWrite  out  1  gated memory write.
- CondEx  out  1  condition passed.
- Flags  out  4  registered {N,Z,C,V}.
- SkipCnt  out  CNT_W  condition-failed instruction count.

Behaviour:
- Reset (reset==0 at rising clk): Flags=4'b0000, SkipCnt=0. Reset has priority over every other input, including mid-stall. Shadow flags (if present) also reset to 0.
- CondEx is combinational from Cond and the registered Flags, never from ALUFlags:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~(C&~Z); GE N==V; LT N!=V; GT ~Z&(N==V); LE ~(~Z&(N==V)); AL 1.
  - 4'b1111: CondEx=0, no X is ever driven.
- Write gating, all combinational, all 0 when En=0:
  - PCSrc = En & PCS & CondEx.
  - RegWrite = En & RegW & CondEx & ~NoWrite.
  - MemWrite = En & MemW & CondEx.
- Flag update, on rising clk with reset==1 and En==1:
  - If FlagW[1]&CondEx: N,Z <= ALUFlags[3:2].
  - If FlagW[0]&CondEx: C,V <= ALUFlags[1:0].
  - Groups are independent; a failed condition leaves the flags unchanged.
  - Latency: a write is visible to CondEx of the next cycle's instruction, not the current one.
- En==0: flags held, counter held (except SkipClr), all write outputs 0.
- SkipCnt, on rising clk:
  - SkipClr=1 -> 0. Clear has priority over a simultaneous increment; that skip event is lost.
  - Else if En & ~CondEx -> SkipCnt+1, saturating at 2^CNT_W-1 (no wrap).
  - Cond=1111 counts as a skip.

Optional Feature:
- Macro: COND_FLAG_SHADOW_EN.
- With the macro:
  - Ports FlagSave (in, 1) and FlagRestore (in, 1) and a 4-bit shadow register are added.
  - FlagSave & En: shadow <= current registered Flags (pre-update value).
  - FlagRestore & En: Flags <= shadow, overriding any FlagW write in the same cycle.
  - Both set in the same cycle: registered flags and shadow swap.
  - Save and restore are not gated by CondEx.
- Without the macro: the ports and shadow register are absent, and behaviour is exactly as above.

Decomposition:
- Package cond_pkg holds:
  - cond_t enum with the 16 4-bit condition codes (EQ..AL, NV=4'b1111).
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flagw group index constants FW_NZ=1, FW_CV=0.
- One sub-module: cond_eval, purely combinational (Cond, Flags -> CondEx), instantiated once.
- Registers, gating and counter live in cond_logic.

Test Plan:
- Reset: hold reset=0 two cycles with FlagW=2'b11, ALUFlags=4'b1111 -> Flags=0000, SkipCnt=0; then Cond=EQ -> CondEx=0.
- Group write: Cond=AL, FlagW=2'b10, ALUFlags=1111 -> Flags=1100 next cycle; then FlagW=2'b01, ALUFlags=0011 -> Flags=1111.
- Latency and gating:
  - With Flags=0000: Cond=EQ, RegW=1, MemW=1, PCS=1, FlagW=11, ALUFlags=0100 -> all write outputs 0, Flags unchanged, SkipCnt +1.
  - Next cycle, with Z still 0 due to the failed write: Cond=NE -> CondEx=1, RegWrite=1; NoWrite=1 forces RegWrite=0.
- Signed compares: Flags=1001 (N=1, V=1) -> GE=1, GT=1, LT=0, LE=0; Flags=1101 -> GT=0, LE=1; Cond=1111 -> CondEx=0.
- Counter: CNT_W=2, four failing cycles -> SkipCnt=3, held at 3; SkipClr with a failing instruction in the same cycle -> 0; En=0 with a failing Cond -> no increment.
- (COND_FLAG_SHADOW_EN) Flags=1010: FlagSave -> shadow=1010; write Flags=0101; FlagRestore with FlagW=11 in the same cycle -> Flags=1010; save+restore together swaps values.

Source files
------------

// File: rtl/cond_pkg.sv
// -----------------------------------------------------------------------------
// cond_pkg
// Shared definitions for the conditional-execution stage of the single-cycle
// ARM core: the 4-bit condition codes, the bit positions of the NZCV flags and
// the FlagW group indices.
// -----------------------------------------------------------------------------
package cond_pkg;

   // Instruction condition field, Instr[31:28].
   typedef enum logic [3:0] {
      EQ = 4'b0000,
      NE = 4'b0001,
      CS = 4'b0010,
      CC = 4'b0011,
      MI = 4'b0100,
      PL = 4'b0101,
      VS = 4'b0110,
      VC = 4'b0111,
      HI = 4'b1000,
      LS = 4'b1001,
      GE = 4'b1010,
      LT = 4'b1011,
      GT = 4'b1100,
      LE = 4'b1101,
      AL = 4'b1110,
      NV = 4'b1111
   } cond_t;

   // Bit positions inside the {N,Z,C,V} flag vector.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Bit positions inside FlagW.
   localparam int FW_NZ = 1;
   localparam int FW_CV = 0;

endpackage : cond_pkg

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational condition evaluator.
// Ports:
//   Cond   in  4  instruction condition field
//   Flags  in  4  registered {N,Z,C,V}
//   CondEx out 1  1 when the condition holds; NV (4'b1111) always gives 0
// -----------------------------------------------------------------------------
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   always_comb begin
      CondEx = 1'b0;
      case (cond_t'(Cond))
         EQ:      CondEx = z;
         NE:      CondEx = ~z;
         CS:      CondEx = c;
         CC:      CondEx = ~c;
         MI:      CondEx = n;
         PL:      CondEx = ~n;
         VS:      CondEx = v;
         VC:      CondEx = ~v;
         HI:      CondEx = c & ~z;
         LS:      CondEx = ~(c & ~z);
         GE:      CondEx = (n == v);
         LT:      CondEx = (n != v);
         GT:      CondEx = ~z & (n == v);
         LE:      CondEx = ~(~z & (n == v));
         AL:      CondEx = 1'b1;
         // NV is reserved: never executes, and never drives X.
         default: CondEx = 1'b0;
      endcase
   end

endmodule : cond_eval

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Conditional-execution stage: holds the NZCV flag register, evaluates the
// instruction condition against the registered flags, gates the PC / register
// / memory writes and counts condition-failed instructions (saturating).
//
// Commit qualifier: an instruction is present and commits on a rising clk edge
// only when En=1; there is no back-pressure. With En=0 every write output is 0
// and flags/counter hold (SkipClr still clears the counter).
//
// Optional feature macro: COND_FLAG_SHADOW_EN adds FlagSave/FlagRestore and a
// 4-bit shadow flag register.
//
// Ports:
//   clk, reset       clock; synchronous active-low reset
//   En               instruction valid / not stalled
//   Cond             condition field Instr[31:28]
//   ALUFlags         {N,Z,C,V} from the ALU this cycle
//   FlagW            [1] write NZ, [0] write CV
//   PCS, RegW, MemW  ungated write requests from the decoder
//   NoWrite          compare-type instruction, suppress register write
//   SkipClr          clear the skipped-instruction counter
//   FlagSave         (macro) copy registered flags into the shadow
//   FlagRestore      (macro) load registered flags from the shadow
//   PCSrc, RegWrite, MemWrite  gated writes
//   CondEx           condition passed
//   Flags            registered {N,Z,C,V}
//   SkipCnt          saturating condition-failed count
// -----------------------------------------------------------------------------
module cond_logic
   import cond_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             En,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic             SkipClr,
`ifdef COND_FLAG_SHADOW_EN
   input  logic             FlagSave,
   input  logic             FlagRestore,
`endif
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] SkipCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Condition uses the registered flags only, so a flag write becomes
   // visible to the next instruction, never the one producing it.
   cond_eval u_cond_eval (
      .Cond   (Cond),
      .Flags  (Flags),
      .CondEx (CondEx)
   );

   assign PCSrc    = En & PCS  & CondEx;
   assign RegWrite = En & RegW & CondEx & ~NoWrite;
   assign MemWrite = En & MemW & CondEx;

`ifdef COND_FLAG_SHADOW_EN
   logic [3:0] shadow;

   // Save captures the pre-update flags; restore overrides any FlagW write.
   // With both asserted the two registers exchange contents.
   always_ff @(posedge clk) begin
      if (!reset) begin
         Flags  <= 4'b0000;
         shadow <= 4'b0000;
      end else if (En) begin
         if (FlagSave)
            shadow <= Flags;
         if (FlagRestore) begin
            Flags <= shadow;
         end else begin
            if (FlagW[FW_NZ] && CondEx)
               Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (FlagW[FW_CV] && CondEx)
               Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!reset) begin
         Flags <= 4'b0000;
      end else if (En) begin
         if (FlagW[FW_NZ] && CondEx)
            Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
         if (FlagW[FW_CV] && CondEx)
            Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
   end
`endif

   // Clear wins over a same-cycle skip; that skip event is dropped.
   always_ff @(posedge clk) begin
      if (!reset)
         SkipCnt <= '0;
      else if (SkipClr)
         SkipCnt <= '0;
      else if (En && !CondEx && (SkipCnt != CNT_MAX))
         SkipCnt <= SkipCnt + CNT_W'(1);
   end

endmodule : cond_logic
